// File: rtl/rca_seq_pkg.sv
// Shared types and helpers for the sequential ripple-carry adder.
// State encoding plus a parameter legality check.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit params_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && (width % chunk == 0);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder built from full adders.
// Also exposes the carry into the top bit for overflow detection.
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry adder: WIDTH bits, CHUNK bits per clock.
// Optional signed overflow output enabled by `RCA_SEQ_OVF_EN.
module rca_seq_adder
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
    $error("rca_seq_adder: illegal WIDTH/CHUNK");
  end

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, res_q, res_nx;
  logic             carry_q;
  logic [IDXW-1:0]  idx;
  logic             accept, last;
  int               off;

  logic [CHUNK-1:0] cs;
  logic             cc;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (idx == LAST);
  assign off    = int'(idx) * CHUNK;

`ifdef RCA_SEQ_OVF_EN
  logic cm;
`else
  logic cm_unused;
`endif

  rca_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_q[off +: CHUNK]),
    .b        (b_q[off +: CHUNK]),
    .cin      (carry_q),
    .s        (cs),
    .cout     (cc),
`ifdef RCA_SEQ_OVF_EN
    .c_msb_in (cm)
`else
    .c_msb_in (cm_unused)
`endif
  );

  // Merge the current chunk's sum into the partial result.
  always_comb begin
    res_nx = res_q;
    res_nx[off +: CHUNK] = cs;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand capture, chunk-by-chunk accumulation, result publish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx     <= '0;
    end else if (state == RUN) begin
      res_q   <= res_nx;
      carry_q <= cc;
      idx     <= idx + IDXW'(1);
      if (last) begin
        sum  <= res_nx;
        cout <= cc;
`ifdef RCA_SEQ_OVF_EN
        ovf  <= cm ^ cc;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rca_seq_adder.sv
// Scoreboard bench for rca_seq_adder (16/4 and 16/16 builds).
// Expected results queued at start, compared on done.
module tb_rca_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start16 = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;

  logic        busy, done, cout;
  logic [15:0] sum;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;
`ifdef RCA_SEQ_OVF_EN
  logic        ovf, ovf16;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [17:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rca_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef RCA_SEQ_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  rca_seq_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
`ifdef RCA_SEQ_OVF_EN
    ,
    .ovf   (ovf16)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic c);
    logic [16:0] full;
    logic        v;
    full = {1'b0, x} + {1'b0, y} + {16'd0, c};
    v = (x[15] == y[15]) && (full[15] != x[15]);
    return {v, full};
  endfunction

  // Compare every done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        chk("sum", {16'd0, sum}, {16'd0, e[15:0]});
        chk("cout", {31'd0, cout}, {31'd0, e[16]});
`ifdef RCA_SEQ_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e[17]});
`endif
      end
    end
  end

  task automatic drive_op(input logic [15:0] x, input logic [15:0] y,
                          input logic c, input bit expect_done);
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    if (expect_done) sb.push_back(model(x, y, c));
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        input logic c, output int nbusy);
    int t;
    drive_op(x, y, c, 1'b1);
    nbusy = 0;
    t = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int nb, t1, t2;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef RCA_SEQ_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Basic op, busy for NCHUNK cycles
    run_op(16'h1234, 16'h4321, 1'b0, nb);
    chk("busy_cycles", nb, 32'd4);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("sum_held", {16'd0, sum}, 32'h5555);

    // Carry boundaries
    run_op(16'hFFFF, 16'h0001, 1'b0, nb);
    run_op(16'h0FFF, 16'h0000, 1'b1, nb);
    run_op(16'h7FFF, 16'h0001, 1'b0, nb);
    run_op(16'hFFFF, 16'h0001, 1'b0, nb);
    run_op(16'h8000, 16'h8000, 1'b1, nb);
    for (int i = 0; i < 4; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), nb);
      chk("busy_rand", nb, 32'd4);
    end
    @(negedge clk);

    // Start during RUN ignored; start held in DONE chains
    drive_op(16'h1111, 16'h2222, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hAAAA;
    b = 16'hAAAA;
    start = 1'b1;
    @(negedge clk);
    drive_op(16'h0F0F, 16'h00F1, 1'b1, 1'b1);
    wait_done(t1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(t2);
    chk("done_spacing", t2 - t1, 32'd5);
    @(negedge clk);

    // Single-chunk build: done two cycles after the start edge
    a = 16'h1234;
    b = 16'h4321;
    cin = 1'b0;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    chk("c16_busy", {31'd0, busy16}, 32'd1);
    chk("c16_early", {31'd0, done16}, 32'd0);
    @(negedge clk);
    chk("c16_done", {31'd0, done16}, 32'd1);
    chk("c16_sum", {16'd0, sum16}, 32'h5555);
    chk("c16_cout", {31'd0, cout16}, 32'd0);
    @(negedge clk);

    // Reset in RUN cycle 2 aborts without a done pulse
    drive_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    run_op(16'hBEEF, 16'h1111, 1'b1, nb);
    chk("post_abort_busy", nb, 32'd4);
    repeat (2) @(negedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
